// File: rtl/activation_arbiter_if.sv
// Handshake bundle between requesters, the activation arbiter and the downstream sink.
// The slave modport is the arbiter side; master is the requester/sink side.
interface activation_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ-1:0]       in_ready;
    logic [NUM_REQ-1:0][31:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [31:0]       out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_last;
    logic                     busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_id,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_id,
        output out_last,
        output busy
    );
endinterface

// File: rtl/activation_arbiter.sv
// Round-robin vector arbiter feeding a registered ReLU activation stage.
// Define ACT_LEAKY_RELU_EN to turn negative inputs into x>>>3 instead of 0.
module activation_arbiter #(
    parameter int VECTOR_LEN = 3,
    parameter int NUM_REQ    = 2
) (
    input logic               clk,
    input logic               rst_n,
    activation_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VECTOR_LEN - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_grant;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    w_pick;
    logic               w_any;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_out_last;
    logic [ID_W-1:0]    r_out_id;
    logic signed [31:0] r_out_data;
    logic signed [31:0] w_din;
    logic signed [31:0] w_act;
    logic [NUM_REQ-1:0] w_rdy;
    logic               w_room;
    logic               w_hs;
    logic               w_vec_end;

    function automatic logic [ID_W-1:0] rr_idx(
        input logic [ID_W-1:0] base,
        input int              off
    );
        int s;
        s = (int'(base) + 1 + off) % NUM_REQ;
        return ID_W'(s);
    endfunction

    assign w_room    = !r_out_valid || bus.out_ready;
    assign w_din     = $signed(bus.in_data[r_grant]);
    assign w_hs      = (r_state == GRANT) && bus.in_valid[r_grant] && w_room;
    assign w_vec_end = w_hs && (r_cnt == CNT_LAST);

    // First valid requester after the previous owner wins.
    always_comb begin
        w_pick = r_last_grant;
        w_any  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && bus.in_valid[rr_idx(r_last_grant, i)]) begin
                w_any  = 1'b1;
                w_pick = rr_idx(r_last_grant, i);
            end
        end
    end

    always_comb begin
        w_rdy = '0;
        if (r_state == GRANT && w_room) begin
            w_rdy[r_grant] = 1'b1;
        end
    end

`ifdef ACT_LEAKY_RELU_EN
    assign w_act = w_din[31] ? (w_din >>> 3) : w_din;
`else
    assign w_act = w_din[31] ? 32'sd0 : w_din;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_nxt = GRANT;
            GRANT:   if (w_vec_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_LAST;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_pick;
            end
            if (w_vec_end) begin
                r_last_grant <= r_grant;
                r_cnt        <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register reloads on a handshake even while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_act;
            r_out_id    <= r_grant;
            r_out_last  <= (r_cnt == CNT_LAST);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_rdy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state == GRANT);
endmodule

// File: tb/tb_activation_arbiter.sv
// Bench for activation_arbiter: vector table plus hand-built corner sequences,
// outputs checked against a scoreboard of expected elements.
module tb_activation_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    activation_arbiter_if #(.NUM_REQ(2)) ifc ();

    activation_arbiter #(
        .VECTOR_LEN(3),
        .NUM_REQ   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    typedef struct {
        int          grp;
        int          req;
        logic [31:0] din;
        logic [31:0] e_relu;
        logic [31:0] e_leaky;
        logic [31:0] id;
        logic [31:0] last;
        int          gap;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] id;
        logic [31:0] last;
        int          gap;
    } exp_t;

    localparam int NV = 18;
    vec_t        tbl [NV];
    exp_t        sb [$];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int n_out    = 0;
    int hold1    = 0;
    int g1_cnt   = 0;
    int g1_after = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [31:0] id,
                            input logic [31:0] last, input int gap);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.last = last;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic load_grp(input int g);
        logic [31:0] e;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].grp == g) begin
`ifdef ACT_LEAKY_RELU_EN
                e = tbl[i].e_leaky;
`else
                e = tbl[i].e_relu;
`endif
                if (tbl[i].req == 0) q0.push_back(tbl[i].din);
                else q1.push_back(tbl[i].din);
                push_exp(e, tbl[i].id, tbl[i].last, tbl[i].gap);
            end
        end
    endtask

    task automatic drive(output bit gap_now);
        bit v0;
        bit v1;
        gap_now = 1'b0;
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        if (v1 && hold1 > 0) begin
            v1 = 1'b0;
            hold1--;
            gap_now = 1'b1;
        end
        ifc.in_valid   = {v1, v0};
        ifc.in_data[0] = v0 ? q0[0] : 32'd0;
        ifc.in_data[1] = v1 ? q1[0] : 32'd0;
    endtask

    task automatic step_neg();
        exp_t        e;
        logic [31:0] tmp;
        @(negedge clk);
        if (ifc.out_valid && ifc.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h want none", ifc.out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", ifc.out_data, e.data);
                chk("out_id", 32'(ifc.out_id), e.id);
                chk("out_last", 32'(ifc.out_last), e.last);
                if (e.gap != 0) chk("out_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
            n_out++;
        end
        if (ifc.in_valid[0] && ifc.in_ready[0] && q0.size() > 0) tmp = q0.pop_front();
        if (ifc.in_valid[1] && ifc.in_ready[1] && q1.size() > 0) begin
            tmp = q1.pop_front();
            g1_cnt++;
            if (g1_cnt == g1_after) hold1 = 3;
        end
    endtask

    task automatic step_pos();
        bit gn;
        @(posedge clk);
        cyc++;
        #1;
        drive(gn);
        if (gn) begin
            chk("gap_in_ready0", 32'(ifc.in_ready[0]), 32'd0);
            chk("gap_busy", 32'(ifc.busy), 32'd1);
        end
    endtask

    task automatic run(input int budget, input string nm);
        for (int k = 0; k < budget; k++) begin
            step_neg();
            step_pos();
            if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
        end
        chk({nm, "_left"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_data", ifc.out_data, 32'd0);
        chk("rst_out_id", 32'(ifc.out_id), 32'd0);
        chk("rst_out_last", 32'(ifc.out_last), 32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_neg();
        chk("post_rst_busy", 32'(ifc.busy), 32'd0);
        chk("post_rst_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("post_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        step_pos();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gn;
        tbl[0]  = '{0, 0, 32'd5,        32'd5,        32'd5,        0, 0, 0};
        tbl[1]  = '{0, 0, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFF, 0, 0, 1};
        tbl[2]  = '{0, 0, 32'd7,        32'd7,        32'd7,        0, 1, 1};
        tbl[3]  = '{0, 0, 32'h80000000, 32'd0,        32'hF0000000, 0, 0, 2};
        tbl[4]  = '{0, 0, 32'd0,        32'd0,        32'd0,        0, 0, 1};
        tbl[5]  = '{0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 1, 1};
        tbl[6]  = '{1, 0, 32'd1,        32'd1,        32'd1,        0, 0, 0};
        tbl[7]  = '{1, 0, 32'd2,        32'd2,        32'd2,        0, 0, 1};
        tbl[8]  = '{1, 0, 32'd3,        32'd3,        32'd3,        0, 1, 1};
        tbl[9]  = '{1, 1, 32'd11,       32'd11,       32'd11,       1, 0, 2};
        tbl[10] = '{1, 1, 32'd12,       32'd12,       32'd12,       1, 0, 1};
        tbl[11] = '{1, 1, 32'd13,       32'd13,       32'd13,       1, 1, 1};
        tbl[12] = '{1, 0, 32'd4,        32'd4,        32'd4,        0, 0, 2};
        tbl[13] = '{1, 0, 32'd5,        32'd5,        32'd5,        0, 0, 1};
        tbl[14] = '{1, 0, 32'd6,        32'd6,        32'd6,        0, 1, 1};
        tbl[15] = '{1, 1, 32'd14,       32'd14,       32'd14,       1, 0, 2};
        tbl[16] = '{1, 1, 32'hFFFFFF9C, 32'd0,        32'hFFFFFFF3, 1, 0, 1};
        tbl[17] = '{1, 1, 32'd16,       32'd16,       32'd16,       1, 1, 1};

        ifc.out_ready = 1'b1;
        ifc.in_valid  = '0;
        ifc.in_data   = '0;
        #2;

        // single requester, then boundary values
        load_grp(0);
        drive(gn);
        do_reset();
        run(40, "grp0");

        // contention after a fresh reset: req0 first
        load_grp(1);
        drive(gn);
        do_reset();
        run(60, "grp1");

        // backpressure on the first output
        ifc.out_ready = 1'b0;
        q0 = '{32'd21, 32'd22, 32'd23};
        push_exp(32'd21, 0, 0, 0);
        push_exp(32'd22, 0, 0, 0);
        push_exp(32'd23, 0, 1, 0);
        drive(gn);
        for (int k = 0; k < 20; k++) begin
            step_neg();
            step_pos();
            if (ifc.out_valid) break;
        end
        chk("bp_seen", 32'(ifc.out_valid), 32'd1);
        for (int j = 0; j < 5; j++) begin
            chk("bp_data", ifc.out_data, 32'd21);
            chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
            step_neg();
            step_pos();
        end
        ifc.out_ready = 1'b1;
        run(30, "bp");

        // req1 owns the grant and pauses mid-vector while req0 waits
        g1_cnt   = 0;
        g1_after = 1;
        q1 = '{32'd31, 32'd32, 32'd33};
        q0 = '{32'd41, 32'd42, 32'd43};
        push_exp(32'd31, 1, 0, 0);
        push_exp(32'd32, 1, 0, 0);
        push_exp(32'd33, 1, 1, 0);
        push_exp(32'd41, 0, 0, 0);
        push_exp(32'd42, 0, 0, 0);
        push_exp(32'd43, 0, 1, 0);
        drive(gn);
        run(60, "gap");
        g1_after = -1;

        // reset after two delivered elements of a vector
        q1 = '{32'd61, 32'd62, 32'd63};
        q0 = '{32'd51, 32'd52, 32'd53};
        push_exp(32'd61, 1, 0, 0);
        push_exp(32'd62, 1, 0, 0);
        n_out = 0;
        drive(gn);
        for (int k = 0; k < 30; k++) begin
            step_neg();
            if (n_out >= 2) break;
            step_pos();
        end
        chk("mid_outs", 32'(n_out), 32'd2);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        q0 = '{32'd71, 32'd72, 32'd73};
        q1 = '{32'd81, 32'd82, 32'd83};
        push_exp(32'd71, 0, 0, 0);
        push_exp(32'd72, 0, 0, 0);
        push_exp(32'd73, 0, 1, 0);
        push_exp(32'd81, 1, 0, 0);
        push_exp(32'd82, 1, 0, 0);
        push_exp(32'd83, 1, 1, 0);
        drive(gn);
        do_reset();
        run(60, "rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/activation_arbiter.md
ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

Interface
REQ-001 Parameter VECTOR_LEN, default 3: number of elements per vector transaction.
REQ-002 Parameter NUM_REQ, default 2: number of requesters sharing the activation lane.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  NUM_REQ  per-requester element valid.
REQ-007 in_ready  output  NUM_REQ  per-requester element accept.
REQ-008 in_data  input  NUM_REQ x 32 signed  per-requester element.
REQ-009 out_valid  output  1  activated element valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  32 signed  activated element.
REQ-012 out_id  output  clog2(NUM_REQ), min 1  index of the requester that owns out_data.
REQ-013 out_last  output  1  out_data is element VECTOR_LEN-1 of its vector.
REQ-014 busy  output  1  a requester currently holds the grant.

Function
REQ-015 FSM states: IDLE, GRANT; reset state IDLE.
REQ-016 IDLE: if any in_valid is high, pick the first requester with in_valid high, searching round-robin from (last_grant+1) mod NUM_REQ, and move to GRANT next cycle; otherwise stay in IDLE.
REQ-017 last_grant resets to NUM_REQ-1, so requester 0 has priority after reset.
REQ-018 The grant is held for exactly VECTOR_LEN accepted elements; no preemption, and in_valid dropping mid-vector does not release the grant.
REQ-019 in_ready[g] = (state==GRANT) && (g==grant) && (!out_valid || out_ready); all other in_ready bits are 0.
REQ-020 Element handshake = in_valid[grant] && in_ready[grant]; each handshake increments the element counter (width clog2(VECTOR_LEN), min 1).
REQ-021 Handshake with counter==VECTOR_LEN-1: clear the counter, update last_grant to grant, and return to IDLE; this leaves a one-cycle bubble before the next grant.
REQ-022 Activation: an input with bit 31 = 1 yields 0 (see REQ-032 for the alternative); otherwise the input is passed unchanged. 0x80000000 yields 0; 0x7FFFFFFF passes unchanged.
REQ-023 Latency: the result is registered and appears on out_data/out_id/out_last with out_valid high in the cycle after the handshake.
REQ-024 out_valid is held, with out_data/out_id/out_last stable, until out_ready is high.
REQ-025 Simultaneous out_ready and a new handshake: the output register reloads and out_valid stays high, sustaining 1 element per cycle.
REQ-026 out_valid && !out_ready: in_ready is 0 and the counter is frozen.
REQ-027 busy = (state==GRANT).

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, counter 0, last_grant NUM_REQ-1, out_valid 0, out_data 0, out_id 0, out_last 0, all in_ready 0, busy 0.
REQ-029 Reset mid-vector drops the partial vector; after reset release, arbitration restarts per REQ-016/017.
REQ-030 No output is driven high in the first cycle after reset deassertion.

Configuration
REQ-031 Macro ACT_LEAKY_RELU_EN.
REQ-032 When ACT_LEAKY_RELU_EN is defined, a negative input yields an arithmetic right shift by 3 (-64 yields -8; -1 yields -1).
REQ-033 When ACT_LEAKY_RELU_EN is undefined, negative inputs yield 0; latency and handshake timing are identical in both builds.

Verification
REQ-034 Single requester: req0 sends {5, -3, 7} with out_ready=1 -> out_data {5, 0, 7} on consecutive cycles, out_id=0, out_last only on 7; leaky build gives {5, -1, 7}.
REQ-035 Contention: req0 and req1 valid continuously -> vector order 0,1,0,1; one IDLE bubble between vectors; out_id changes only after out_last.
REQ-036 Backpressure: hold out_ready=0 for 4 cycles after the first output -> out_data stable, in_ready=0, no element lost or duplicated; the full vector is delivered after release.
REQ-037 Gap in input: req1 granted, deasserts in_valid after element 1 for 3 cycles while req0 is valid -> grant stays with req1 until its 3rd element.
REQ-038 Reset mid-vector after 2 elements -> all outputs 0 in the same cycle; after release, req0 wins if both are valid.
REQ-039 Boundaries: inputs 0x80000000, 0x00000000, 0x7FFFFFFF -> 0, 0, 0x7FFFFFFF (non-leaky build).
